// File: rtl/neurram_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : neurram_spi_pkg
// Brief    : Shared word width and shift-engine state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package neurram_spi_pkg;

    localparam int WORD_W = 32;

    localparam logic [1:0] C_ST_IDLE  = 2'b00;
    localparam logic [1:0] C_ST_FETCH = 2'b01;
    localparam logic [1:0] C_ST_LOW   = 2'b10;
    localparam logic [1:0] C_ST_HIGH  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = C_ST_IDLE,
        ST_FETCH = C_ST_FETCH,
        ST_LOW   = C_ST_LOW,
        ST_HIGH  = C_ST_HIGH
    } spi_state_t;

endpackage
`default_nettype wire

// File: rtl/neurram_spi_clkdiv.sv
`default_nettype none
// ============================================================================
// Module   : neurram_spi_clkdiv
// Brief    : Phase counter for the shift clock; strikes phase start/end and
//            drives the registered shift clock while enabled.
// Revision : 1.0 - initial release
// ============================================================================
module neurram_spi_clkdiv #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic phase_start,
    output logic phase_end,
    output logic spi_clk
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] r_cnt;
    logic             r_spi_clk;

    assign phase_start = en && (r_cnt == '0);
    assign phase_end   = en && (r_cnt == DIV_W'(CLK_DIV - 1));
    assign spi_clk     = r_spi_clk;

    // Every HIGH phase ends on a toggle back to low, so leaving the enabled
    // phases always parks the clock low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_spi_clk <= 1'b0;
        end else if (!en) begin
            r_cnt     <= '0;
            r_spi_clk <= 1'b0;
        end else if (phase_end) begin
            r_cnt     <= '0;
            r_spi_clk <= ~r_spi_clk;
        end else begin
            r_cnt     <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/neurram_spi_shifter.sv
`default_nettype none
// ============================================================================
// Module   : neurram_spi_shifter
// Brief    : Word-stream to bit-serial scan-chain shifter with MISO readback.
// Revision : 1.0 - initial release
// ============================================================================
module neurram_spi_shifter
    import neurram_spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_bits,
    input  logic [31:0]       din_data,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic [31:0]       dout_data,
    output logic              dout_valid,
    output logic              state_spi_clk,
    output logic              state_spi_idle
);

    localparam int IDX_W = $clog2(WORD_W);

    spi_state_t         r_state;
    spi_state_t         w_next;
    logic [CNT_W-1:0]   r_remain;
    logic [IDX_W-1:0]   r_bit_idx;
    logic [WORD_W-1:0]  r_out;
    logic [WORD_W-1:0]  r_cap;
    logic [IDX_W:0]     r_cap_cnt;
    logic [WORD_W-1:0]  r_dout_data;
    logic               r_dout_valid;

    logic               w_en;
    logic               w_phase_start;
    logic               w_phase_end;
    logic               w_last_high;
    logic               w_sample;
    logic               w_final_bit;
    logic [WORD_W-1:0]  w_cap_shift;
    logic [WORD_W-1:0]  w_cap_val;
    logic [IDX_W:0]     w_cap_cnt_val;
    logic               w_emit_full;
    logic               w_emit_end;

    assign w_en = (r_state == ST_LOW) || (r_state == ST_HIGH);

    neurram_spi_clkdiv #(
        .CLK_DIV (CLK_DIV)
    ) u_clkdiv (
        .clk         (clk),
        .rst         (rst),
        .en          (w_en),
        .phase_start (w_phase_start),
        .phase_end   (w_phase_end),
        .spi_clk     (state_spi_clk)
    );

    assign w_last_high = (r_state == ST_HIGH) && w_phase_end;
    assign w_sample    = (r_state == ST_HIGH) && w_phase_start;
    assign w_final_bit = (r_remain == CNT_W'(1));

    // Capture view including this cycle's sample, which matters when the
    // first and last HIGH cycle coincide (CLK_DIV == 1).
    assign w_cap_shift   = {r_cap[WORD_W-2:0], spi_miso};
    assign w_cap_val     = w_sample ? w_cap_shift : r_cap;
    assign w_cap_cnt_val = w_sample ? (r_cap_cnt + 1'b1) : r_cap_cnt;
    assign w_emit_full   = w_sample && (r_cap_cnt == (IDX_W+1)'(WORD_W - 1));
    assign w_emit_end    = w_last_high && w_final_bit && !w_emit_full
                           && (w_cap_cnt_val != '0);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start && (num_bits != '0)) w_next = ST_FETCH;
            ST_FETCH: if (din_valid) w_next = ST_LOW;
            ST_LOW:   if (w_phase_end) w_next = ST_HIGH;
            ST_HIGH: begin
                if (w_phase_end) begin
                    if (w_final_bit)             w_next = ST_IDLE;
                    else if (r_bit_idx == '0)    w_next = ST_FETCH;
                    else                         w_next = ST_LOW;
                end
            end
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_remain     <= '0;
            r_bit_idx    <= '0;
            r_out        <= '0;
            r_cap        <= '0;
            r_cap_cnt    <= '0;
            r_dout_data  <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_dout_valid <= 1'b0;

            if ((r_state == ST_IDLE) && start && (num_bits != '0))
                r_remain <= num_bits;

            if ((r_state == ST_FETCH) && din_valid) begin
                r_out     <= din_data;
                r_bit_idx <= IDX_W'(WORD_W - 1);
            end

            if (w_last_high) begin
                r_remain  <= r_remain - 1'b1;
                r_bit_idx <= r_bit_idx - 1'b1;
                r_out     <= {r_out[WORD_W-2:0], 1'b0};
            end

            if (w_emit_full) begin
                r_dout_data  <= w_cap_shift;
                r_dout_valid <= 1'b1;
                r_cap        <= '0;
                r_cap_cnt    <= '0;
            end else if (w_emit_end) begin
                r_dout_data  <= w_cap_val;
                r_dout_valid <= 1'b1;
                r_cap        <= '0;
                r_cap_cnt    <= '0;
            end else if (w_sample) begin
                r_cap        <= w_cap_shift;
                r_cap_cnt    <= r_cap_cnt + 1'b1;
            end
        end
    end

    assign din_ready      = (r_state == ST_FETCH);
    assign state_spi_idle = (r_state == ST_IDLE);
    assign spi_mosi       = w_en && r_out[WORD_W-1];
    assign dout_data      = r_dout_data;
    assign dout_valid     = r_dout_valid;

endmodule
`default_nettype wire

// File: tb/tb_neurram_spi_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tb_neurram_spi_shifter
// Brief    : Directed self-checking bench; CLK_DIV=2 and CLK_DIV=1 instances.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_neurram_spi_shifter;

    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          sel = 1'b0;
    logic          loop2 = 1'b0;
    logic          miso_val = 1'b0;
    logic [CW-1:0] num_bits = '0;
    logic [31:0]   din_data = '0;
    logic          din_valid = 1'b0;

    logic        ready2, mosi2, dvalid2, sclk2, idle2, miso2, start2, valid2;
    logic [31:0] ddata2;
    logic        ready1, mosi1, dvalid1, sclk1, idle1, start1, valid1;
    logic [31:0] ddata1;

    logic        w_ready, w_mosi, w_dvalid, w_clk, w_idle;
    logic [31:0] w_ddata;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] words [0:3];
    int          delays [0:3];
    logic [31:0] dq [0:3];
    int          fetch_len [0:3];
    int          edges, idle_low, dcount, bad_phase;
    logic [63:0] mosi_bits;
    logic        timed_out;

    always #5 clk = ~clk;

    assign start2 = start & ~sel;
    assign valid2 = din_valid & ~sel;
    assign start1 = start & sel;
    assign valid1 = din_valid & sel;
    assign miso2  = loop2 ? mosi2 : miso_val;

    assign w_ready  = sel ? ready1  : ready2;
    assign w_mosi   = sel ? mosi1   : mosi2;
    assign w_dvalid = sel ? dvalid1 : dvalid2;
    assign w_clk    = sel ? sclk1   : sclk2;
    assign w_idle   = sel ? idle1   : idle2;
    assign w_ddata  = sel ? ddata1  : ddata2;

    neurram_spi_shifter #(.CLK_DIV(2), .CNT_W(CW)) dut2 (
        .clk (clk), .rst (rst), .start (start2), .num_bits (num_bits),
        .din_data (din_data), .din_valid (valid2), .din_ready (ready2),
        .spi_mosi (mosi2), .spi_miso (miso2), .dout_data (ddata2),
        .dout_valid (dvalid2), .state_spi_clk (sclk2), .state_spi_idle (idle2)
    );

    neurram_spi_shifter #(.CLK_DIV(1), .CNT_W(CW)) dut1 (
        .clk (clk), .rst (rst), .start (start1), .num_bits (num_bits),
        .din_data (din_data), .din_valid (valid1), .din_ready (ready1),
        .spi_mosi (mosi1), .spi_miso (mosi1), .dout_data (ddata1),
        .dout_valid (dvalid1), .state_spi_clk (sclk1), .state_spi_idle (idle1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one transfer on the selected instance, feeding words[] with the
    // per-word FETCH delays and gathering MOSI/clock/readback observations.
    task automatic run_xfer(input logic [CW-1:0] nb, input int pulse_at);
        int   widx = 0;
        int   fcnt = 0;
        int   cyc  = 0;
        int   hrun = 0;
        int   lrun = 0;
        int   div;
        logic prev = 1'b0;
        div = sel ? 1 : 2;
        edges = 0; idle_low = 0; dcount = 0; bad_phase = 0; mosi_bits = '0;
        for (int i = 0; i < 4; i++) fetch_len[i] = 0;
        num_bits = nb;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        while (w_idle !== 1'b1 && cyc < 4000) begin
            idle_low++;
            if (w_clk && !prev) begin
                edges++;
                mosi_bits = {mosi_bits[62:0], w_mosi};
            end
            prev = w_clk;
            if (w_clk) hrun++;
            else if (hrun > 0) begin
                if (hrun != div) bad_phase++;
                hrun = 0;
            end
            if (!w_clk && !w_ready) lrun++;
            else if (lrun > 0) begin
                if (lrun != div) bad_phase++;
                lrun = 0;
            end
            if (w_dvalid) begin
                if (dcount < 4) dq[dcount] = w_ddata;
                dcount++;
            end
            if (din_valid) begin
                din_valid = 1'b0;
                widx++;
                fcnt = 0;
            end else if (w_ready) begin
                fcnt++;
                if (widx < 4 && fcnt > delays[widx]) begin
                    din_data        = words[widx];
                    din_valid       = 1'b1;
                    fetch_len[widx] = fcnt;
                end
            end
            start = (cyc == pulse_at);
            if (cyc == pulse_at) num_bits = 16'd5;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        if (hrun > 0 && hrun != div) bad_phase++;
        if (w_dvalid) begin
            if (dcount < 4) dq[dcount] = w_ddata;
            dcount++;
        end
        timed_out = (cyc >= 4000);
    endtask

    initial begin
        int   e;
        int   cyc;
        int   seen;
        logic prev;

        for (int i = 0; i < 4; i++) begin
            words[i] = '0; delays[i] = 0; dq[i] = '0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_idle",   w_idle,   1'b1);
        check("rst_clk",    w_clk,    1'b0);
        check("rst_mosi",   w_mosi,   1'b0);
        check("rst_ready",  w_ready,  1'b0);
        check("rst_dvalid", w_dvalid, 1'b0);
        check("rst_ddata",  w_ddata,  32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 8 bits of A5, MISO held high
        miso_val = 1'b1;
        words[0] = 32'hA500_0000;
        run_xfer(16'd8, -1);
        check("t1_timeout",  timed_out, 1'b0);
        check("t1_mosi",     mosi_bits, 64'hA5);
        check("t1_edges",    edges,     8);
        check("t1_idle_low", idle_low,  1 + 8*4);
        check("t1_phase",    bad_phase, 0);
        check("t1_dcount",   dcount,    1);
        check("t1_dout",     dq[0],     32'h0000_00FF);

        // Zero-length start is ignored
        num_bits = '0;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        check("t3_idle0",  w_idle,  1'b1);
        check("t3_ready0", w_ready, 1'b0);
        @(negedge clk);
        check("t3_idle1",  w_idle,  1'b1);
        check("t3_ready1", w_ready, 1'b0);

        // Start pulsed mid-transfer is ignored
        run_xfer(16'd8, 12);
        check("t4_timeout",  timed_out, 1'b0);
        check("t4_edges",    edges,     8);
        check("t4_idle_low", idle_low,  33);
        check("t4_mosi",     mosi_bits, 64'hA5);
        check("t4_dout",     dq[0],     32'h0000_00FF);
        @(negedge clk);
        check("t4_after_idle", w_idle, 1'b1);

        // 40 bits across two words, stalled word 2, MISO looped back
        loop2    = 1'b1;
        words[0] = 32'hDEAD_BEEF;
        words[1] = 32'h8000_0000;
        delays[1] = 5;
        run_xfer(16'd40, -1);
        delays[1] = 0;
        check("t2_timeout",  timed_out,    1'b0);
        check("t2_edges",    edges,        40);
        check("t2_mosi",     mosi_bits,    64'hDE_ADBE_EF80);
        check("t2_fetch2",   fetch_len[1], 6);
        check("t2_idle_low", idle_low,     1 + 32*4 + 6 + 8*4);
        check("t2_phase",    bad_phase,    0);
        check("t2_dcount",   dcount,       2);
        check("t2_dout0",    dq[0],        32'hDEAD_BEEF);
        check("t2_dout1",    dq[1],        32'h0000_0080);

        // Reset during bit 10 of a 32-bit transfer
        num_bits  = 16'd32;
        din_data  = 32'h1234_5678;
        din_valid = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e = 0; cyc = 0; seen = 0; prev = 1'b0;
        while (e < 10 && cyc < 500) begin
            if (w_clk && !prev) e++;
            prev = w_clk;
            if (w_dvalid) seen++;
            cyc++;
            @(negedge clk);
        end
        check("t5_reach_bit10", e, 10);
        din_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("t5_idle",   w_idle,   1'b1);
        check("t5_clk",    w_clk,    1'b0);
        check("t5_mosi",   w_mosi,   1'b0);
        check("t5_ready",  w_ready,  1'b0);
        check("t5_dvalid", w_dvalid, 1'b0);
        check("t5_ddata",  w_ddata,  32'h0);
        rst = 1'b0;
        repeat (40) begin
            if (w_dvalid) seen++;
            @(negedge clk);
        end
        check("t5_no_dvalid", seen,   0);
        check("t5_still_idle", w_idle, 1'b1);
        words[0] = 32'h1234_5678;
        run_xfer(16'd32, -1);
        check("t5_timeout", timed_out, 1'b0);
        check("t5_edges",   edges,     32);
        check("t5_dcount",  dcount,    1);
        check("t5_dout",    dq[0],     32'h1234_5678);

        // CLK_DIV=1 instance, 64 bits looped back
        sel      = 1'b1;
        words[0] = 32'hCAFE_F00D;
        words[1] = 32'h0F1E_2D3C;
        @(negedge clk);
        run_xfer(16'd64, -1);
        check("t6_timeout",  timed_out, 1'b0);
        check("t6_edges",    edges,     64);
        check("t6_mosi",     mosi_bits, 64'hCAFE_F00D_0F1E_2D3C);
        check("t6_phase",    bad_phase, 0);
        check("t6_idle_low", idle_low,  1 + 32*2 + 1 + 32*2);
        check("t6_dcount",   dcount,    2);
        check("t6_dout0",    dq[0],     32'hCAFE_F00D);
        check("t6_dout1",    dq[1],     32'h0F1E_2D3C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
